// File: rtl/round_ctrl.sv
// Round sequencer for the 24 game: captures a puzzle index, pulses load, runs the round countdown and keeps score.
// Optional countdown enabled by defining ROUND_TIMER_EN; without it secs_left and timeout are tied to 0.
module round_ctrl #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int ROUND_SECS    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       restart,
  input  logic       solved,
  input  logic [3:0] index_in,
  output logic       rand_enable,
  output logic [3:0] index_q,
  output logic       load,
  output logic       round_active,
  output logic [6:0] secs_left,
  output logic [7:0] score,
  output logic       timeout,
  output logic [1:0] state
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

  state_t st;
  logic   first_cap;
  logic   expire;

  if (TICKS_PER_SEC < 2 || ROUND_SECS < 1 || ROUND_SECS > 127) begin : g_bad_cfg
    $error("round_ctrl: TICKS_PER_SEC must be >= 2 and ROUND_SECS in 1..127");
  end

  // Avoid showing the same puzzle twice in a row, except on the first pick of a session.
  function automatic logic [3:0] pick_index(input logic [3:0] cand, input logic [3:0] cur,
                                            input logic first);
    if (!first && cand == cur) return cand + 4'd1;
    return cand;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] s);
    return (s == 8'hFF) ? s : s + 8'd1;
  endfunction

  assign state        = st;
  assign rand_enable  = (st != LOAD);
  assign round_active = (st == PLAY);

`ifdef ROUND_TIMER_EN
  localparam int PW = $clog2(TICKS_PER_SEC);

  logic [PW-1:0] prescaler;
  logic [6:0]    secs_r;
  logic          tick;

  assign tick      = (st == PLAY) && (prescaler == PW'(TICKS_PER_SEC - 1));
  assign expire    = tick && (secs_r == 7'd1);
  assign secs_left = secs_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      secs_r    <= '0;
    end else if (restart) begin
      prescaler <= '0;
      secs_r    <= '0;
    end else if (st == LOAD) begin
      prescaler <= '0;
      secs_r    <= 7'(ROUND_SECS);
    end else if (st == PLAY) begin
      if (tick) begin
        prescaler <= '0;
        if (secs_r != 7'd0) secs_r <= secs_r - 7'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end
`else
  assign expire    = 1'b0;
  assign secs_left = 7'd0;
`endif

  // Round FSM; load and timeout are single-cycle registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      index_q   <= 4'd0;
      first_cap <= 1'b1;
      load      <= 1'b0;
      timeout   <= 1'b0;
      score     <= 8'd0;
    end else begin
      load    <= 1'b0;
      timeout <= 1'b0;
      if (restart) begin
        st        <= IDLE;
        score     <= 8'd0;
        first_cap <= 1'b1;
      end else begin
        case (st)
          IDLE: if (start) begin
            index_q   <= pick_index(index_in, index_q, first_cap);
            first_cap <= 1'b0;
            score     <= 8'd0;
            load      <= 1'b1;
            st        <= LOAD;
          end
          LOAD: st <= PLAY;
          PLAY: if (solved || start) begin
            index_q   <= pick_index(index_in, index_q, first_cap);
            first_cap <= 1'b0;
            if (solved) score <= sat_inc(score);
            load      <= 1'b1;
            st        <= LOAD;
          end else if (expire) begin
            timeout <= 1'b1;
            st      <= OVER;
          end
          OVER: if (start) begin
            index_q   <= pick_index(index_in, index_q, first_cap);
            first_cap <= 1'b0;
            score     <= 8'd0;
            load      <= 1'b1;
            st        <= LOAD;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule
